// File: rtl/i2c_pkg.sv
// Shared I2C definitions: protocol constants, slave FSM states and register reset image.
package i2c_pkg;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE_DATA,
        ST_WRITE_ACK,
        ST_READ_DATA,
        ST_READ_ACK
    } i2c_state_e;

    // Power-on contents of the slave register file
    function automatic logic [7:0] reg_reset_val(input int unsigned idx);
        case (idx)
            0:       return 8'hAA;
            1:       return 8'hBB;
            2:       return 8'hCC;
            3:       return 8'hDD;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Host-side view of the I2C slave: register read port, write strobe and busy flag.
interface i2c_slave_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0] host_idx;
    logic [7:0]       host_rdata;
    logic             wr_pulse;
    logic [7:0]       wr_data;
    logic [IDX_W-1:0] wr_idx;
    logic             busy;

    modport slave  (input  host_idx, output host_rdata, wr_pulse, wr_data, wr_idx, busy);
    modport master (output host_idx, input  host_rdata, wr_pulse, wr_data, wr_idx, busy);
endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizer for SCL/SDA plus SCL edge and START/STOP condition detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Reset to the idle-high bus level so no spurious edge follows reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a small byte register file; auto-incrementing pointer, host read port.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = I2C_DEFAULT_ADDR,
    parameter int unsigned DEPTH      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2c_scl,
    inout  wire           i2c_sda,
    i2c_slave_if.slave    host
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    i2c_state_e       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             rw_q, rw_d;
    logic             wr_en_c;
    logic [7:0]       rx_byte_c;
    logic             wr_pulse_q;
    logic [7:0]       wr_data_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [7:0]       regs_q [DEPTH];

    logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (i2c_scl),
        .sda_i    (i2c_sda),
        .scl      (scl_s),
        .sda      (sda_s),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .start    (start_s),
        .stop     (stop_s)
    );

    assign rx_byte_c = {shift_q[6:0], sda_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        wr_en_c   = 1'b0;
        if (stop_s) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_s) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            ptr_d     = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise_s) begin
                    shift_d   = rx_byte_c;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        if (rx_byte_c[7:1] == SLAVE_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = rx_byte_c[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // First fall starts the ACK; the fall ending it also presents the read MSB
                ST_ADDR_ACK: if (scl_fall_s) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        state_d   = ST_READ_DATA;
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = 4'd1;
                    end else begin
                        state_d   = ST_WRITE_DATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                ST_WRITE_DATA: if (scl_rise_s) begin
                    shift_d   = rx_byte_c;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        wr_en_c   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: if (scl_fall_s) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_q + IDX_W'(1);
                        state_d  = ST_WRITE_DATA;
                    end
                end
                // bit_cnt 0 means the next byte has not been loaded yet
                ST_READ_DATA: if (scl_fall_s) begin
                    if (bit_cnt_q == 4'd0) begin
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = 4'd1;
                    end else if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_READ_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oe_d  = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                ST_READ_ACK: if (scl_rise_s) begin
                    if (sda_s == I2C_ACK) begin
                        ptr_d     = ptr_q + IDX_W'(1);
                        bit_cnt_d = '0;
                        state_d   = ST_READ_DATA;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // While SCL is high the line may only be released, never newly pulled low
        if (scl_s) sda_oe_d = sda_oe_d & sda_oe_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_data_q  <= '0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            wr_pulse_q <= wr_en_c;
            if (wr_en_c) begin
                wr_data_q <= rx_byte_c;
                wr_idx_q  <= ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= reg_reset_val(i);
        end else if (wr_en_c) begin
            regs_q[ptr_q] <= rx_byte_c;
        end
    end

    assign i2c_sda         = sda_oe_q ? 1'b0 : 1'bz;
    assign host.host_rdata = regs_q[host.host_idx];
    assign host.wr_pulse   = wr_pulse_q;
    assign host.wr_data    = wr_data_q;
    assign host.wr_idx     = wr_idx_q;
    assign host.busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master against i2c_slave on a pulled-up bus, with write/read scoreboards.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int          Q     = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_if #(.DEPTH(DEPTH)) hif ();

    i2c_slave #(.SLAVE_ADDR(7'h50), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .i2c_scl (m_scl),
        .i2c_sda (sda_bus),
        .host    (hif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         wr_cnt = 0;
    int         drive_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] last_wr_data = 8'h00;
    logic [1:0] last_wr_idx = 2'd0;
    int         last_wr_cyc = 0;
    int         last_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: write strobes, slave-driven low level, busy cycles
    always @(negedge clk) begin
        if (hif.wr_pulse === 1'b1) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_data <= hif.wr_data;
            last_wr_idx  <= hif.wr_idx;
            last_wr_cyc  <= cyc;
        end
        if (sda_bus === 1'b0 && !m_sda_low) drive_cnt <= drive_cnt + 1;
        if (hif.busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } wr_exp_t;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] exp;
    } reg_vec_t;

    wr_exp_t    wr_q[$];
    logic [7:0] rd_q[$];
    reg_vec_t   reset_tbl[4];
    reg_vec_t   write_tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; m_scl = 1'b1; tick(Q);
        m_sda_low = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_rstart();
        m_sda_low = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda_low = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda_low = 1'b0; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; tick(Q);
        m_scl = 1'b1; last_rise_cyc = cyc; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        b = sda_bus; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(ack_bit);
    endtask

    // Push the expected store, send the byte, then pop and compare against the strobe seen
    task automatic write_data_byte(input logic [7:0] d, input logic [1:0] idx);
        logic    ack;
        int      n0;
        int      lat;
        wr_exp_t e;
        wr_q.push_back('{idx: idx, data: d});
        n0 = wr_cnt;
        write_byte(d, ack);
        chk($sformatf("wr_ack_%02h", d), 32'(ack), 32'(I2C_ACK));
        chk($sformatf("wr_pulse_cnt_%02h", d), 32'(wr_cnt - n0), 32'd1);
        e = wr_q.pop_front();
        chk($sformatf("wr_idx_%02h", d), 32'(last_wr_idx), 32'(e.idx));
        chk($sformatf("wr_data_%02h", d), 32'(last_wr_data), 32'(e.data));
        lat = last_wr_cyc - last_rise_cyc;
        chk($sformatf("wr_latency_%02h", d), 32'(lat >= 1 && lat <= 4), 32'd1);
    endtask

    task automatic read_data_byte(input logic ack_bit);
        logic [7:0] d;
        logic [7:0] e;
        read_byte(ack_bit, d);
        e = rd_q.pop_front();
        chk($sformatf("rd_byte_%02h", e), 32'(d), 32'(e));
    endtask

    task automatic check_regs(input string name, input reg_vec_t tbl[4]);
        for (int i = 0; i < 4; i++) begin
            hif.host_idx = tbl[i].idx;
            #1;
            chk($sformatf("%s_%0d", name, i), 32'(hif.host_rdata), 32'(tbl[i].exp));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic b;
        int   n_drv, n_busy, n_wr;

        reset_tbl[0] = '{idx: 2'd0, exp: 8'hAA};
        reset_tbl[1] = '{idx: 2'd1, exp: 8'hBB};
        reset_tbl[2] = '{idx: 2'd2, exp: 8'hCC};
        reset_tbl[3] = '{idx: 2'd3, exp: 8'hDD};
        write_tbl[0] = '{idx: 2'd0, exp: 8'h00};
        write_tbl[1] = '{idx: 2'd1, exp: 8'h0F};
        write_tbl[2] = '{idx: 2'd2, exp: 8'hF0};
        write_tbl[3] = '{idx: 2'd3, exp: 8'h55};

        // Reset state
        hif.host_idx = 2'd0;
        rst = 1'b1;
        tick(4);
        chk("rst_busy", 32'(hif.busy), 32'd0);
        chk("rst_wr_pulse", 32'(hif.wr_pulse), 32'd0);
        chk("rst_wr_data", 32'(hif.wr_data), 32'd0);
        chk("rst_wr_idx", 32'(hif.wr_idx), 32'd0);
        chk("rst_sda", 32'(sda_bus), 32'd1);
        rst = 1'b0;
        tick(4);
        check_regs("rst_reg", reset_tbl);

        // Read four bytes, NACK on the last
        bus_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        chk("rd_busy", 32'(hif.busy), 32'd1);
        rd_q.push_back(8'hAA); rd_q.push_back(8'hBB);
        rd_q.push_back(8'hCC); rd_q.push_back(8'hDD);
        for (int i = 0; i < 4; i++) read_data_byte(i == 3 ? I2C_NACK : I2C_ACK);
        n_drv = drive_cnt;
        tick(2 * Q);
        chk("rd_sda_released", 32'(sda_bus), 32'd1);
        chk("rd_no_drive_after_nack", 32'(drive_cnt - n_drv), 32'd0);
        bus_stop();
        tick(4);
        chk("rd_busy_after_stop", 32'(hif.busy), 32'd0);

        // Write four bytes
        bus_start();
        write_byte(8'hA0, ack);
        chk("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 4; i++) write_data_byte(write_tbl[i].exp, 2'(i));
        bus_stop();
        tick(4);
        chk("wr_busy_after_stop", 32'(hif.busy), 32'd0);
        check_regs("wr_reg", write_tbl);

        // Wrong address: NACK, no activity
        n_drv = drive_cnt; n_busy = busy_cnt; n_wr = wr_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        chk("bad_addr_nack", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h12, ack);
        chk("bad_addr_data_nack", 32'(ack), 32'(I2C_NACK));
        bus_stop();
        tick(4);
        chk("bad_addr_no_drive", 32'(drive_cnt - n_drv), 32'd0);
        chk("bad_addr_no_busy", 32'(busy_cnt - n_busy), 32'd0);
        chk("bad_addr_no_wr", 32'(wr_cnt - n_wr), 32'd0);

        // Five writes wrap the pointer; repeated START reads from index 0
        bus_start();
        write_byte(8'hA0, ack);
        chk("wrap_addr_ack", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 5; i++) write_data_byte(8'(8'h11 * (i + 1)), 2'(i % 4));
        hif.host_idx = 2'd0;
        #1;
        chk("wrap_reg0", 32'(hif.host_rdata), 32'h55);
        bus_rstart();
        write_byte(8'hA1, ack);
        chk("rstart_addr_ack", 32'(ack), 32'(I2C_ACK));
        rd_q.push_back(8'h55);
        read_data_byte(I2C_NACK);
        bus_stop();
        tick(4);

        // Reset in the middle of a driven read bit
        bus_start();
        write_byte(8'hA1, ack);
        chk("rst_mid_addr_ack", 32'(ack), 32'(I2C_ACK));
        rd_q.push_back(8'h55);
        read_data_byte(I2C_ACK);
        read_bit(b); chk("rst_mid_bit7", 32'(b), 32'd0);
        read_bit(b); chk("rst_mid_bit6", 32'(b), 32'd0);
        read_bit(b); chk("rst_mid_bit5", 32'(b), 32'd1);
        m_sda_low = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        chk("rst_mid_driven", 32'(sda_bus), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_sda_z", 32'(sda_bus), 32'd1);
        chk("rst_mid_busy", 32'(hif.busy), 32'd0);
        chk("rst_mid_wr_pulse", 32'(hif.wr_pulse), 32'd0);
        chk("rst_mid_wr_data", 32'(hif.wr_data), 32'd0);
        hif.host_idx = 2'd1;
        #1;
        chk("rst_mid_reg1", 32'(hif.host_rdata), 32'hBB);
        n_drv = drive_cnt;
        tick(Q);
        m_scl = 1'b0;
        rst = 1'b0;
        tick(Q);
        bus_stop();
        tick(4);
        chk("rst_mid_no_drive", 32'(drive_cnt - n_drv), 32'd0);

        // Full write after the mid-transaction reset
        bus_start();
        write_byte(8'hA0, ack);
        chk("post_rst_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_data_byte(8'h99, 2'd0);
        write_data_byte(8'h77, 2'd1);
        bus_stop();
        tick(4);
        write_tbl[0].exp = 8'h99;
        write_tbl[1].exp = 8'h77;
        write_tbl[2].exp = 8'hCC;
        write_tbl[3].exp = 8'hDD;
        check_regs("post_rst_reg", write_tbl);
        chk("post_rst_busy", 32'(hif.busy), 32'd0);

        chk("wr_scoreboard_empty", 32'(wr_q.size()), 32'd0);
        chk("rd_scoreboard_empty", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit target address matched after START.
REQ-002 Parameter DEPTH, default 4, number of byte registers in the internal register file, power of two.
REQ-003 clk  input  1  system clock; all logic clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i2c_scl  input  1  I2C clock from the master; open-drain bus, no clock stretching.
REQ-006 i2c_sda  inout  1  I2C data; the block only drives 0 or z.
REQ-007 host_idx  input  $clog2(DEPTH)  host-side register read index.
REQ-008 host_rdata  output  8  register[host_idx], combinational.
REQ-009 wr_pulse  output  1  one-clk pulse when a received data byte is stored.
REQ-010 wr_data  output  8  byte just stored; valid while wr_pulse is high.
REQ-011 wr_idx  output  $clog2(DEPTH)  register index written; valid while wr_pulse is high.
REQ-012 busy  output  1  high from an address-matched START until STOP or NACK return to IDLE.

Function
REQ-013 SCL and SDA shall pass through a 2-FF synchronizer; edges shall be detected on the synchronized copies (rise/fall = 1-clk pulses).
REQ-014 START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
REQ-015 The FSM shall have states IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK.
REQ-016 START from any state, including a repeated START, shall go to ADDR, clear the bit counter, and reset the byte pointer to 0.
REQ-017 STOP from any state shall go to IDLE, release SDA, and drop busy the next clk.
REQ-018 ADDR: shift 8 bits MSB-first on SCL rise. If bits[7:1]==SLAVE_ADDR, go to ADDR_ACK; otherwise go to IDLE without driving SDA.
REQ-019 ADDR_ACK: drive SDA low from the SCL fall after bit 8 until the next SCL fall. Then go to READ_DATA if R/W=1, else WRITE_DATA.
REQ-020 WRITE_DATA: sample SDA on each SCL rise. After the 8th bit, store the byte into register[ptr], pulse wr_pulse one clk with wr_data/wr_idx, then go to WRITE_ACK.
REQ-021 WRITE_ACK: drive SDA low for one SCL period (fall to fall), increment ptr modulo DEPTH (DEPTH-1 wraps to 0), then return to WRITE_DATA.
REQ-022 READ_DATA: load register[ptr] on entry. Present the MSB on SDA at the first SCL fall and shift on each subsequent SCL fall. Drive low for 0, z for 1. After 8 bits release SDA and go to READ_ACK.
REQ-023 READ_ACK: sample SDA on SCL rise. If 0 (ACK), increment ptr with wrap and return to READ_DATA. If 1 (NACK), go to IDLE, keep SDA released, and ignore SCL until the next START.
REQ-024 SDA output changes only on synced SCL fall (plus STOP/reset release), never while SCL is high, except when released.
REQ-025 If a host-side read and an I2C write target the same index in one clk, host_rdata shall return the old value; the new value is visible the next clk.
REQ-026 Latency: wr_pulse asserts within 2 clk of the synchronized 8th SCL rise of a data byte.

Reset
REQ-027 On rst: state=IDLE, SDA released (z), busy=0, wr_pulse=0, wr_data=0, wr_idx=0, ptr=0, bit counter=0.
REQ-028 On rst: registers load 8'hAA, 8'hBB, 8'hCC, 8'hDD for indices 0-3; indices >= 4 load 0.
REQ-029 Reset mid-transaction shall release SDA within the same cycle (asynchronous) and ignore the bus until the next START.

Structure
REQ-030 The FSM state enum and the I2C constants (ACK=0, NACK=1, default address) shall live in the shared package i2c_pkg, reused by i2c_master.
REQ-031 The synchronizer and START/STOP/edge detector shall be one sub-module, i2c_bus_sync, with outputs scl, sda, scl_rise, scl_fall, start, stop.

Verification
REQ-032 Bench drives i2c_master against i2c_slave on a pulled-up bus; the master's ACK check is the pass criterion.
REQ-033 Write 0x50+W, then 00,0F,F0,55 -> four ACKs; wr_pulse x4 with idx 0..3; host_rdata shows 00,0F,F0,55 afterwards.
REQ-034 After reset, read 0x50+R of 4 bytes with ACK,ACK,ACK,NACK -> rx AA,BB,CC,DD; SDA released after NACK; busy=0 after STOP.
REQ-035 Address 0x51 write -> NACK at the address bit; no wr_pulse; SDA never driven; busy stays 0.
REQ-036 Write 5 bytes 11..55 -> idx 0,1,2,3,0; register[0]=55. Then repeated START to read -> first byte read is 55 (ptr reset to 0).
REQ-037 Assert rst during bit 4 of a read byte -> SDA is z in the same cycle and outputs take their reset values. The next full write succeeds.
